// File: rtl/codec_spi_pkg.sv
// Shared types and constants for the codec SPI arbiter.
package codec_spi_pkg;

  localparam int DEF_SPI_DATA_WIDTH = 32;

  localparam logic PORT_INIT = 1'b0;
  localparam logic PORT_CTRL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2,
    ST_HOLD = 2'd3
  } arb_state_e;

  function automatic logic [1:0] port_onehot(input logic idx);
    port_onehot = idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/codec_spi_arbiter_rr_pick.sv
// Combinational two-way round-robin pick; in hold mode only the locked port is eligible.
module spi_arb_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       hold_en,
  input  logic       hold_port,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = ~last;
    if (hold_en) begin
      gnt_valid = req[hold_port];
      gnt_idx   = hold_port;
    end else begin
      case (req)
        2'b01:   begin gnt_valid = 1'b1; gnt_idx = 1'b0;  end
        2'b10:   begin gnt_valid = 1'b1; gnt_idx = 1'b1;  end
        2'b11:   begin gnt_valid = 1'b1; gnt_idx = ~last; end
        default: begin gnt_valid = 1'b0; gnt_idx = ~last; end
      endcase
    end
  end

endmodule

// File: rtl/codec_spi_arbiter.sv
// Shares the codec SPI master between the init sequencer (port 0) and runtime control (port 1).
// Optional XFER timeout is enabled with macro SPI_ARB_TIMEOUT_EN.
module codec_spi_arbiter
  import codec_spi_pkg::*;
#(
  parameter int SPI_DATA_WIDTH = DEF_SPI_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [1:0]                i_req,
  input  logic [SPI_DATA_WIDTH-1:0] i_data0,
  input  logic [SPI_DATA_WIDTH-1:0] i_data1,
  input  logic [1:0]                i_lock,
  output logic [1:0]                o_ack,
  output logic [1:0]                o_done,
  output logic                      o_spi_enable,
  output logic [SPI_DATA_WIDTH-1:0] o_spi_data,
  input  logic                      i_spi_done,
  input  logic                      i_spi_busy,
  output logic                      o_owner,
  output logic                      o_active,
  output logic                      o_timeout
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_e                state, state_nxt;
  logic                      last_grant, last_nxt;
  logic [1:0]                ack_nxt, done_nxt;
  logic                      enable_nxt, owner_nxt, active_nxt;
  logic [SPI_DATA_WIDTH-1:0] data_nxt;
  logic                      gnt_valid, gnt_idx;
  logic                      xfer_end;
  logic                      timeout_hit;

  spi_arb_rr_pick u_pick (
    .req       (i_req),
    .last      (last_grant),
    .hold_en   (state == ST_HOLD),
    .hold_port (o_owner),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] xfer_cnt, cnt_nxt;
  logic             timeout_nxt;

  // Done wins over a timeout landing on the same edge.
  assign timeout_hit = (state == ST_XFER) && !i_spi_done &&
                       (xfer_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_nxt     = xfer_cnt;
    timeout_nxt = 1'b0;
    if (state == ST_XFER) begin
      if (timeout_hit) timeout_nxt = 1'b1;
      else             cnt_nxt     = xfer_cnt + 1'b1;
    end else begin
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      xfer_cnt  <= '0;
      o_timeout <= 1'b0;
    end else begin
      xfer_cnt  <= cnt_nxt;
      o_timeout <= timeout_nxt;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  assign xfer_end = i_spi_done || timeout_hit;

  always_comb begin
    state_nxt  = state;
    last_nxt   = last_grant;
    ack_nxt    = 2'b00;
    done_nxt   = 2'b00;
    enable_nxt = o_spi_enable;
    data_nxt   = o_spi_data;
    owner_nxt  = o_owner;
    active_nxt = o_active;
    case (state)
      ST_IDLE, ST_HOLD: begin
        if (!i_spi_busy && gnt_valid) begin
          data_nxt   = gnt_idx ? i_data1 : i_data0;
          enable_nxt = 1'b1;
          ack_nxt    = port_onehot(gnt_idx);
          owner_nxt  = gnt_idx;
          active_nxt = 1'b1;
          last_nxt   = gnt_idx;
          state_nxt  = ST_XFER;
        end else if (state == ST_HOLD && !i_lock[o_owner] && !i_req[o_owner]) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (xfer_end) begin
          enable_nxt = 1'b0;
          active_nxt = 1'b0;
          done_nxt   = port_onehot(o_owner);
          state_nxt  = ST_GAP;
        end
      end
      ST_GAP: begin
        state_nxt = i_lock[o_owner] ? ST_HOLD : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // last_grant resets to port 1 so the init sequencer wins the first pick.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      last_grant   <= PORT_CTRL;
      o_ack        <= 2'b00;
      o_done       <= 2'b00;
      o_spi_enable <= 1'b0;
      o_spi_data   <= '0;
      o_owner      <= PORT_INIT;
      o_active     <= 1'b0;
    end else begin
      state        <= state_nxt;
      last_grant   <= last_nxt;
      o_ack        <= ack_nxt;
      o_done       <= done_nxt;
      o_spi_enable <= enable_nxt;
      o_spi_data   <= data_nxt;
      o_owner      <= owner_nxt;
      o_active     <= active_nxt;
    end
  end

endmodule

// File: tb/tb_codec_spi_arbiter.sv
// Directed self-checking bench for codec_spi_arbiter (timeout checks follow SPI_ARB_TIMEOUT_EN).
module tb_codec_spi_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req, lock, ack, done;
  logic [31:0] data0, data1, spi_data;
  logic        spi_enable, spi_done, spi_busy, owner, active, timeout;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  codec_spi_arbiter #(.SPI_DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_req        (req),
    .i_data0      (data0),
    .i_data1      (data1),
    .i_lock       (lock),
    .o_ack        (ack),
    .o_done       (done),
    .o_spi_enable (spi_enable),
    .o_spi_data   (spi_data),
    .i_spi_done   (spi_done),
    .i_spi_busy   (spi_busy),
    .o_owner      (owner),
    .o_active     (active),
    .o_timeout    (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic complete_xfer(input string tag, input logic [1:0] exp_done);
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_en_low"}, 32'(spi_enable), 32'd0);
    chk({tag, "_inactive"}, 32'(active), 32'd0);
  endtask

  initial begin
    int cnt;
    logic [1:0] exp_g;
    logic [31:0] exp_d;

    reset = 1'b1; req = 2'b00; lock = 2'b00;
    data0 = '0; data1 = '0; spi_done = 1'b0; spi_busy = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_en", 32'(spi_enable), 32'd0);
    chk("rst_data", spi_data, 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    reset = 1'b0;

    // single request on port 0, done seen 20 cycles after launch
    data0 = 32'h0040_0007; req = 2'b01;
    tick();
    chk("t1_ack", 32'(ack), 32'h1);
    chk("t1_en", 32'(spi_enable), 32'd1);
    chk("t1_data", spi_data, 32'h0040_0007);
    chk("t1_owner", 32'(owner), 32'd0);
    chk("t1_active", 32'(active), 32'd1);
    req = 2'b00;
    tick();
    chk("t1_ack_pulse", 32'(ack), 32'd0);
    cnt = 0;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (spi_enable === 1'b1) cnt++;
    end
    chk("t1_en_held", 32'(cnt), 32'd18);
    complete_xfer("t1", 2'b01);
    tick();
    chk("t1_done_pulse", 32'(done), 32'd0);

    // contention: last grant was port 0, so port 1 goes first
    data0 = 32'hA0A0_0001; data1 = 32'hB1B1_0002; req = 2'b11;
    exp_g = 2'b10;
    for (int k = 0; k < 4; k++) begin
      exp_d = (exp_g == 2'b10) ? data1 : data0;
      tick();
      chk($sformatf("cont%0d_ack", k), 32'(ack), 32'(exp_g));
      chk($sformatf("cont%0d_data", k), spi_data, exp_d);
      if (k == 0) data1 = 32'hB1B1_0003;
      tick();
      chk($sformatf("cont%0d_hold_data", k), spi_data, exp_d);
      tick();
      complete_xfer($sformatf("cont%0d", k), exp_g);
      tick();
      chk($sformatf("cont%0d_gap", k), 32'(ack), 32'd0);
      exp_g = ~exp_g;
    end
    req = 2'b00;

    // lock: port 0 bursts 3 words while port 1 waits
    data0 = 32'hC000_0001; req = 2'b01; lock = 2'b01;
    tick();
    chk("lock_w1_ack", 32'(ack), 32'h1);
    data1 = 32'hD000_00D1; req = 2'b11;
    for (int w = 2; w <= 3; w++) begin
      tick(); tick();
      complete_xfer($sformatf("lock_w%0d_prev", w), 2'b01);
      tick();
      chk($sformatf("lock_w%0d_gap", w), 32'(ack), 32'd0);
      data0 = 32'hC000_0000 + 32'(w);
      tick();
      chk($sformatf("lock_w%0d_ack", w), 32'(ack), 32'h1);
      chk($sformatf("lock_w%0d_data", w), spi_data, 32'hC000_0000 + 32'(w));
    end
    req = 2'b10;
    tick(); tick();
    complete_xfer("lock_w3", 2'b01);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ack !== 2'b00) cnt++;
    end
    chk("lock_p1_wait", 32'(cnt), 32'd0);
    lock = 2'b00;
    tick();
    chk("lock_drop_idle", 32'(ack), 32'd0);
    tick();
    chk("lock_p1_ack", 32'(ack), 32'h2);
    chk("lock_p1_data", spi_data, 32'hD000_00D1);
    chk("lock_p1_owner", 32'(owner), 32'd1);
    req = 2'b00;
    tick();
    complete_xfer("lock_p1", 2'b10);
    tick();

    // busy gating
    spi_busy = 1'b1; data0 = 32'hE000_000E; req = 2'b01;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ack !== 2'b00 || spi_enable !== 1'b0) cnt++;
    end
    chk("busy_no_launch", 32'(cnt), 32'd0);
    spi_busy = 1'b0;
    tick();
    chk("busy_launch_ack", 32'(ack), 32'h1);
    chk("busy_launch_data", spi_data, 32'hE000_000E);
    req = 2'b00;
    tick();
    complete_xfer("busy", 2'b01);
    tick();

    // reset in the middle of a port-1 transfer
    data1 = 32'hF000_000F; req = 2'b10;
    tick();
    chk("rstx_ack", 32'(ack), 32'h2);
    req = 2'b00;
    tick();
    reset = 1'b1;
    #1;
    chk("rstx_en", 32'(spi_enable), 32'd0);
    chk("rstx_active", 32'(active), 32'd0);
    chk("rstx_data", spi_data, 32'd0);
    chk("rstx_owner", 32'(owner), 32'd0);
    chk("rstx_strobes", {28'd0, ack, done}, 32'd0);
    @(negedge clock);
    reset = 1'b0; req = 2'b11;
    tick();
    chk("rstx_first_grant", 32'(ack), 32'h1);
    req = 2'b00;
    tick();
    complete_xfer("rstx", 2'b01);
    tick();

    // no done from the SPI master
    req = 2'b10;
    tick();
    chk("to_ack", 32'(ack), 32'h2);
    req = 2'b00;
`ifdef SPI_ARB_TIMEOUT_EN
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (spi_enable === 1'b1 && timeout === 1'b0) cnt++;
    end
    chk("to_en_held", 32'(cnt), 32'd7);
    tick();
    chk("to_en_low", 32'(spi_enable), 32'd0);
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_done", 32'(done), 32'h2);
    chk("to_inactive", 32'(active), 32'd0);
    tick();
    chk("to_pulse_end", 32'(timeout), 32'd0);
`else
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (spi_enable === 1'b1 && timeout === 1'b0) cnt++;
    end
    chk("to_wait_forever", 32'(cnt), 32'd20);
    complete_xfer("to", 2'b10);
`endif
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
